// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM state, control bundle and constants for the hazard controller
package hazard_ctrl_pkg;
    typedef enum logic {RUN, HALT} state_t;
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_zero;
        logic idex_zero;
        logic exmem_zero;
        logic memwb_zero;
    } ctrl_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam ctrl_t CTRL_RUN   = ctrl_t'(9'b11111_0000);
    localparam ctrl_t CTRL_STALL = ctrl_t'(9'b00111_0100);
    localparam ctrl_t CTRL_BR    = ctrl_t'(9'b11111_1100);
    localparam ctrl_t CTRL_HALT  = ctrl_t'(9'b00000_0000);
    localparam ctrl_t CTRL_RST   = ctrl_t'(9'b00000_1111);
endpackage

// File: rtl/mdu_occupancy_cnt.sv
// mdu_occupancy_cnt: load/decrement counter tracking how long HI/LO stays busy
module mdu_occupancy_cnt #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int W = $clog2(MAXC + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (start) cnt <= is_div ? W'(DIV_CYCLES) : W'(MUL_CYCLES);
        else if (cnt != '0) cnt <= cnt - W'(1);
    end
    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush generation, halt FSM and stall-cycle counter
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_uses_hilo,
    input  logic        ex_memtoreg,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_mdu_start,
    input  logic        ex_is_div,
    input  logic        branch_taken,
    input  logic        halt_req,
    input  logic        go,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_zero,
    output logic        idex_zero,
    output logic        exmem_zero,
    output logic        memwb_zero,
    output logic        mdu_busy,
    output logic        halted,
    output logic [31:0] stall_cycles
);
    state_t state, state_nx;
    ctrl_t  c;
    logic   lu, mh;
    mdu_occupancy_cnt #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (ex_mdu_start && state == RUN),
        .is_div (ex_is_div),
        .busy   (mdu_busy)
    );
    assign lu = ex_memtoreg && ex_wreg != REG_ZERO &&
                ((id_uses_rs && id_rs == ex_wreg) || (id_uses_rt && id_rt == ex_wreg));
    assign mh = mdu_busy && id_uses_hilo;
    // Reset forces flushes combinationally so the pipeline is cleared while rst is held
    always_comb begin
        c = rst ? CTRL_RST : state == HALT ? CTRL_HALT : branch_taken ? CTRL_BR :
            (lu || mh) ? CTRL_STALL : CTRL_RUN;
        state_nx = (state == RUN && halt_req) ? HALT : (state == HALT && go) ? RUN : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            stall_cycles <= '0;
        end else begin
            state <= state_nx;
            if (state == RUN && !c.pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
        end
    end
    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_zero, idex_zero, exmem_zero, memwb_zero} = c;
    assign halted = (state == HALT);
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench driving directed vectors into hazard_ctrl
module tb_hazard_ctrl;
    localparam logic [8:0] C_RUN   = 9'b11111_0000;
    localparam logic [8:0] C_STALL = 9'b00111_0100;
    localparam logic [8:0] C_BR    = 9'b11111_1100;
    localparam logic [8:0] C_HALT  = 9'b00000_0000;
    localparam logic [8:0] C_RST   = 9'b00000_1111;
    typedef struct packed {
        logic [8:0]  ctrl;
        logic        busy;
        logic        halted;
        logic [31:0] sc;
    } exp_t;
    logic clk = 0, rst = 1;
    logic [4:0] id_rs = 0, id_rt = 0, ex_wreg = 0;
    logic id_uses_rs = 0, id_uses_rt = 0, id_uses_hilo = 0, ex_memtoreg = 0;
    logic ex_mdu_start = 0, ex_is_div = 0, branch_taken = 0, halt_req = 0, go = 0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_zero, idex_zero, exmem_zero, memwb_zero, mdu_busy, halted;
    logic [31:0] stall_cycles;
    exp_t  q[$];
    string nq[$];
    int checks = 0, fails = 0;
    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .ex_memtoreg(ex_memtoreg), .ex_wreg(ex_wreg), .ex_mdu_start(ex_mdu_start),
        .ex_is_div(ex_is_div), .branch_taken(branch_taken), .halt_req(halt_req), .go(go),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_zero(ifid_zero), .idex_zero(idex_zero),
        .exmem_zero(exmem_zero), .memwb_zero(memwb_zero), .mdu_busy(mdu_busy),
        .halted(halted), .stall_cycles(stall_cycles)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t  e;
            string n;
            logic [8:0] act;
            e = q.pop_front();
            n = nq.pop_front();
            act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_zero, idex_zero, exmem_zero, memwb_zero};
            checks += 4;
            if (act !== e.ctrl) begin fails++; $display("FAIL %s ctrl got %b want %b", n, act, e.ctrl); end
            if (mdu_busy !== e.busy) begin fails++; $display("FAIL %s mdu_busy got %b want %b", n, mdu_busy, e.busy); end
            if (halted !== e.halted) begin fails++; $display("FAIL %s halted got %b want %b", n, halted, e.halted); end
            if (stall_cycles !== e.sc) begin fails++; $display("FAIL %s stall_cycles got %0d want %0d", n, stall_cycles, e.sc); end
        end
    end
    task automatic cyc(input logic [8:0] c, input logic b, input logic h, input logic [31:0] sc, input string n);
        q.push_back('{ctrl: c, busy: b, halted: h, sc: sc});
        nq.push_back(n);
        @(posedge clk);
        #1;
    endtask
    initial begin
        @(posedge clk);
        #1;
        cyc(C_RST, 0, 0, 0, "reset");
        rst = 0;
        cyc(C_RUN, 0, 0, 0, "idle");
        ex_memtoreg = 1; ex_wreg = 8; id_rs = 8; id_uses_rs = 1;
        cyc(C_STALL, 0, 0, 0, "load_use");
        ex_memtoreg = 0;
        cyc(C_RUN, 0, 0, 1, "load_use_done");
        ex_memtoreg = 1; ex_wreg = 0; id_rs = 0;
        cyc(C_RUN, 0, 0, 1, "lu_reg_zero");
        ex_wreg = 8; id_rs = 8; id_uses_rs = 0;
        cyc(C_RUN, 0, 0, 1, "lu_rs_unused");
        id_rt = 8; id_uses_rt = 1;
        cyc(C_STALL, 0, 0, 1, "load_use_rt");
        branch_taken = 1;
        cyc(C_BR, 0, 0, 2, "branch_beats_lu");
        branch_taken = 0; ex_memtoreg = 0; id_uses_rt = 0;
        cyc(C_RUN, 0, 0, 2, "after_branch");
        ex_mdu_start = 1; ex_is_div = 1;
        cyc(C_RUN, 0, 0, 2, "div_start");
        ex_mdu_start = 0; ex_is_div = 0; id_uses_hilo = 1;
        for (int i = 0; i < 32; i++) cyc(C_STALL, 1, 0, 32'(2 + i), "div_busy");
        cyc(C_RUN, 0, 0, 34, "div_done");
        id_uses_hilo = 0; halt_req = 1;
        cyc(C_RUN, 0, 0, 34, "halt_req");
        halt_req = 0;
        cyc(C_HALT, 0, 1, 34, "halted");
        branch_taken = 1; halt_req = 1;
        cyc(C_HALT, 0, 1, 34, "halt_beats_branch");
        branch_taken = 0; halt_req = 0;
        cyc(C_HALT, 0, 1, 34, "halted");
        cyc(C_HALT, 0, 1, 34, "halted");
        go = 1;
        cyc(C_HALT, 0, 1, 34, "go");
        cyc(C_RUN, 0, 0, 34, "resumed_go_ignored");
        go = 0;
        cyc(C_RUN, 0, 0, 34, "run");
        ex_mdu_start = 1;
        cyc(C_RUN, 0, 0, 34, "mul_start");
        ex_mdu_start = 0;
        cyc(C_RUN, 1, 0, 34, "mul_busy");
        rst = 1;
        cyc(C_RST, 0, 0, 0, "async_rst");
        rst = 0; id_uses_hilo = 1;
        cyc(C_RUN, 0, 0, 0, "post_rst");
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
